// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns a decoded memory access into a req/gnt/rvalid bus
// transaction, stalls the core meanwhile and returns extended load data.
// Optional access timeout fault is enabled with `define LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_load,
  input  logic          is_store,
  input  logic [2:0]    func3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata_ext,
  output logic          fault,
  output logic [1:0]    fault_cause,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] CauseMisalign = 2'd1;
  localparam logic [1:0] CauseIllegal  = 2'd2;
  localparam logic [1:0] CauseTimeout  = 2'd3;

  state_t        state;
  logic [2:0]    func3_q;
  logic [1:0]    off_q;
  logic          illegal_c;
  logic          misalign_c;
  logic [3:0]    wstrb_c;
  logic [DW-1:0] wdata_rep_c;
  logic [DW-1:0] rshift_c;
  logic [DW-1:0] rext_c;
  logic          tmo_hit;

  // Decode-time fault classification; illegal outranks misaligned.
  always_comb begin
    illegal_c  = 1'b0;
    misalign_c = 1'b0;
    if (is_load == is_store) begin
      illegal_c = 1'b1;
    end else if (is_load && (func3 == 3'd3 || func3[2:1] == 2'b11)) begin
      illegal_c = 1'b1;
    end else if (is_store && func3 > 3'd2) begin
      illegal_c = 1'b1;
    end
    if (func3[1:0] == 2'd1 && addr[0]) begin
      misalign_c = 1'b1;
    end else if (func3[1:0] == 2'd2 && addr[1:0] != 2'b00) begin
      misalign_c = 1'b1;
    end
  end

  // Store lane replication and byte strobes.
  always_comb begin
    wstrb_c     = 4'b1111;
    wdata_rep_c = wdata;
    case (func3[1:0])
      2'd0: begin
        wstrb_c     = 4'b0001 << addr[1:0];
        wdata_rep_c = DW'({4{wdata[7:0]}});
      end
      2'd1: begin
        wstrb_c     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = DW'({2{wdata[15:0]}});
      end
      default: begin
        wstrb_c     = 4'b1111;
        wdata_rep_c = wdata;
      end
    endcase
  end

  // Load lane extraction and extension.
  always_comb begin
    rshift_c = mem_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'd0:    rext_c = {{(DW-8){rshift_c[7]}}, rshift_c[7:0]};
      3'd1:    rext_c = {{(DW-16){rshift_c[15]}}, rshift_c[15:0]};
      3'd4:    rext_c = {{(DW-8){1'b0}}, rshift_c[7:0]};
      3'd5:    rext_c = {{(DW-16){1'b0}}, rshift_c[15:0]};
      default: rext_c = rshift_c;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counts cycles spent waiting on the bus; restarts per phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (state == IDLE || (state == REQ && mem_gnt)) begin
      tmo_cnt <= 8'd0;
    end else if (state == REQ || state == WAIT) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid)) &&
                   (tmo_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  assign stall = (state == IDLE && start) || state == REQ || state == WAIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      func3_q     <= 3'd0;
      off_q       <= 2'd0;
      done        <= 1'b0;
      rdata_ext   <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal_c || misalign_c) begin
              fault       <= 1'b1;
              fault_cause <= illegal_c ? CauseIllegal : CauseMisalign;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              fault       <= 1'b0;
              fault_cause <= 2'd0;
              func3_q     <= func3;
              off_q       <= addr[1:0];
              mem_req     <= 1'b1;
              mem_we      <= is_store;
              mem_addr    <= {addr[AW-1:2], 2'b00};
              mem_wdata   <= is_store ? wdata_rep_c : '0;
              mem_wstrb   <= is_store ? wstrb_c : 4'd0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (tmo_hit) begin
            mem_req     <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= CauseTimeout;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_ext <= rext_c;
            done      <= 1'b1;
            state     <= DONE;
          end else if (tmo_hit) begin
            fault       <= 1'b1;
            fault_cause <= CauseTimeout;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected completions are queued at issue and
// compared when done pulses; bus behaviour is checked cycle by cycle.
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO = 4;
  localparam int BP = 2;
`else
  localparam int unsigned TMO = 255;
  localparam int BP = 5;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        f;
    logic [1:0]  c;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata_ext;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] model_rd = 32'd0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  lsu_ctrl #(.AW(32), .DW(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata_ext(rdata_ext), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued access.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rdata_ext", rdata_ext, mon_e.rd);
        chk("fault", 32'(fault), 32'(mon_e.f));
        chk("fault_cause", 32'(fault_cause), 32'(mon_e.c));
        chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  // gw/rw: cycles to withhold gnt / rvalid (gw < 0 never grants).
  task automatic access(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gw, input int rw,
                        input logic [31:0] exp_rd, input logic [1:0] cause, input int lat,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                        input logic [3:0] exp_strb);
    int   n;
    int   req_n;
    int   wait_n;
    bit   fin;
    bit   granted;
    bit   saw_req;
    exp_t e;
    n = 0; req_n = 0; wait_n = 0; fin = 0; granted = 0; saw_req = 0;
    @(posedge clk); #1;
    is_load = ld; is_store = st; func3 = f3; addr = a; wdata = wd; start = 1'b1;
    if (cause == 2'd0 && ld && !st) model_rd = exp_rd;
    e.rd = model_rd; e.f = (cause != 2'd0); e.c = cause; e.lat = lat; e.t0 = cyc;
    sb_q.push_back(e);
    while (!fin && n < 80) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        saw_req = 1;
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_wdata"}, mem_wdata, exp_wd);
        chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
        chk({tag, "_we"}, 32'(mem_we), 32'(st));
        if (gw >= 0 && req_n == gw) begin
          mem_gnt = 1'b1;
          granted = !st;
        end
        req_n++;
      end else if (granted) begin
        if (wait_n == rw) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd;
        end
        wait_n++;
      end
      @(negedge clk);
      chk({tag, "_stall"}, 32'(stall), 32'(!done));
      if (done) fin = 1;
      @(posedge clk); #1;
      n++;
    end
    if (!fin) chk({tag, "_no_done"}, 32'd0, 32'd1);
    chk({tag, "_bus_used"}, 32'(saw_req), 32'(cause == 2'd0 || cause == 2'd3));
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_req_idle"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; func3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_rdata", rdata_ext, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    access("lw",  1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 2'd0, 3, 32'h100, 32'h0, 4'b0000);
    access("lb",  1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 32'hFFFFFF80, 2'd0, 3, 32'h100, 32'h0, 4'b0000);
    access("lbu", 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 32'h00000080, 2'd0, 3, 32'h100, 32'h0, 4'b0000);
    access("lhu", 1, 0, 3'd5, 32'h102, 32'h0, 32'h80FF0000, 0, 0, 32'h000080FF, 2'd0, 3, 32'h100, 32'h0, 4'b0000);
    access("sb",  0, 1, 3'd0, 32'h201, 32'h12345678, 32'h0, 0, 0, 32'h0, 2'd0, 2, 32'h200, 32'h78787878, 4'b0010);
    access("sh",  0, 1, 3'd1, 32'h202, 32'h12345678, 32'h0, 0, 0, 32'h0, 2'd0, 2, 32'h200, 32'h56785678, 4'b1100);
    access("lw_mis", 1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 32'h0, 2'd1, 1, 32'h0, 32'h0, 4'b0000);
    access("st_f3",  0, 1, 3'd3, 32'h200, 32'h0, 32'h0, 0, 0, 32'h0, 2'd2, 1, 32'h0, 32'h0, 4'b0000);
    access("ld_st",  1, 1, 3'd2, 32'h200, 32'h0, 32'h0, 0, 0, 32'h0, 2'd2, 1, 32'h0, 32'h0, 4'b0000);
    access("ill_mis", 1, 0, 3'd6, 32'h101, 32'h0, 32'h0, 0, 0, 32'h0, 2'd2, 1, 32'h0, 32'h0, 4'b0000);
    access("sw_bp", 0, 1, 3'd2, 32'h300, 32'hA5A5C3C3, 32'h0, BP, 0, 32'h0, 2'd0, 2 + BP, 32'h300, 32'hA5A5C3C3, 4'b1111);
    access("lh_sx", 1, 0, 3'd1, 32'h106, 32'h0, 32'h80011234, 1, 2, 32'hFFFF8001, 2'd0, 6, 32'h104, 32'h0, 4'b0000);
    access("sb_b0", 0, 1, 3'd0, 32'h40C, 32'h000000C4, 32'h0, 0, 0, 32'h0, 2'd0, 2, 32'h40C, 32'hC4C4C4C4, 4'b0001);
    access("lb_pos", 1, 0, 3'd0, 32'h401, 32'h0, 32'h00007F00, 0, 1, 32'h0000007F, 2'd0, 4, 32'h400, 32'h0, 4'b0000);

    // Reset asserted while the load sits in WAIT; the late response must be dropped.
    @(posedge clk); #1;
    is_load = 1'b1; is_store = 1'b0; func3 = 3'd2; addr = 32'h500; start = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_rdata", rdata_ext, 32'd0);
    model_rd = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; is_load = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("late_rvalid_done", 32'(done), 32'd0);
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_req", 32'(mem_req), 32'd0);
      chk("post_rst_rdata", rdata_ext, 32'd0);
    end

`ifdef LSU_TIMEOUT_EN
    access("tmo", 1, 0, 3'd2, 32'h600, 32'h0, 32'h0, -1, 0, 32'h0, 2'd3, 5, 32'h600, 32'h0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo_quiet_done", 32'(done), 32'd0);
      chk("tmo_quiet_req", 32'(mem_req), 32'd0);
    end
`else
    access("lw_slow", 1, 0, 3'd2, 32'h600, 32'h0, 32'h0BADF00D, 20, 7, 32'h0BADF00D, 2'd0, 30, 32'h600, 32'h0, 4'b0000);
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
